// File: rtl/reset_sequencer_pkg.sv
// Shared types for the reset sequencer: FSM state encoding, reset-cause codes, width helper.
// Pure declarations; no logic, no latency, no flow control.
package reset_seq_pkg;

   typedef enum logic [2:0] {
      HOLD        = 3'd0,
      WAIT_LOCK   = 3'd1,
      PERIPH_WAIT = 3'd2,
      CPU_WAIT    = 3'd3,
      RUN         = 3'd4,
      SW_PULSE    = 3'd5
   } seq_state_t;

   typedef logic [1:0] cause_t;

   localparam cause_t CAUSE_POR  = 2'd0;
   localparam cause_t CAUSE_SW   = 2'd1;
   localparam cause_t CAUSE_WDT  = 2'd2;
   localparam cause_t CAUSE_LOCK = 2'd3;

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Control/status bundle between the reset sequencer (master) and the SoC reset fabric (slave).
// Plain wires; no latency, no backpressure.
interface reset_sequencer_if;

   logic       pll_locked;
   logic       sw_reset_req;
   logic       wdt_kick;
   logic       periph_resetn;
   logic       cpu_resetn;
   logic       seq_done;
   logic [1:0] rst_cause;

   modport master (
      input  pll_locked, sw_reset_req, wdt_kick,
      output periph_resetn, cpu_resetn, seq_done, rst_cause
   );

   modport slave (
      output pll_locked, sw_reset_req, wdt_kick,
      input  periph_resetn, cpu_resetn, seq_done, rst_cause
   );

endinterface

// File: rtl/reset_delay_counter.sv
// Saturating up-counter with synchronous clear and a terminal-count flag against a loaded limit.
// Count updates one edge after inc/clr; tc is combinational from the count register; no backpressure.
module reset_delay_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset_in,
   input  logic         clr,
   input  logic         inc,
   input  logic [W-1:0] term,
   output logic         tc
);

   logic [W-1:0] count_q;

   always_ff @(posedge clk) begin
      if (reset_in) begin
         count_q <= '0;
      end else if (clr) begin
         count_q <= '0;
      end else if (inc && (count_q != {W{1'b1}})) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign tc = (count_q == term);

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release (peripherals, then CPU) with SW / lock-loss / optional watchdog restart (RESET_SEQ_WATCHDOG_EN).
// All outputs registered from next state (1-edge latency, no input-to-output path); no backpressure.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int LOCK_FILTER  = 4,
   parameter int PERIPH_DELAY = 8,
   parameter int CPU_DELAY    = 16,
   parameter int SW_PULSE_LEN = 4,
   parameter int WDT_CYCLES   = 1024
) (
   input  logic              clk,
   input  logic              reset_in,
   reset_sequencer_if.master bus
);

   localparam int SEQ_MAX = max_of(max_of(LOCK_FILTER, PERIPH_DELAY), max_of(CPU_DELAY, SW_PULSE_LEN));
   localparam int SEQ_W   = $clog2(SEQ_MAX + 1);

   seq_state_t       state_q, state_d;
   cause_t           cause_q, cause_d;
   logic             periph_q, periph_d;
   logic             run_q, run_d;
   logic [SEQ_W-1:0] seq_term;
   logic             seq_clr;
   logic             seq_tc;
   logic             wdt_expire;

   // One shared delay counter; its limit follows whichever state is waiting.
   always_comb begin
      seq_term = '0;
      case (state_q)
         WAIT_LOCK:   seq_term = SEQ_W'(LOCK_FILTER - 1);
         PERIPH_WAIT: seq_term = SEQ_W'(PERIPH_DELAY - 1);
         CPU_WAIT:    seq_term = SEQ_W'(CPU_DELAY - 1);
         SW_PULSE:    seq_term = SEQ_W'(SW_PULSE_LEN - 1);
         default:     seq_term = '0;
      endcase
   end

   assign seq_clr = (state_d != state_q) || ((state_q == WAIT_LOCK) && !bus.pll_locked);

   reset_delay_counter #(.W(SEQ_W)) u_seq_cnt (
      .clk      (clk),
      .reset_in (reset_in),
      .clr      (seq_clr),
      .inc      (1'b1),
      .term     (seq_term),
      .tc       (seq_tc)
   );

`ifdef RESET_SEQ_WATCHDOG_EN
   localparam int WDT_W = $clog2(WDT_CYCLES + 1);
   logic wdt_tc;

   reset_delay_counter #(.W(WDT_W)) u_wdt_cnt (
      .clk      (clk),
      .reset_in (reset_in),
      .clr      ((state_q != RUN) || bus.wdt_kick),
      .inc      (state_q == RUN),
      .term     (WDT_W'(WDT_CYCLES - 1)),
      .tc       (wdt_tc)
   );

   // A kick landing on the terminal cycle rescues the system.
   assign wdt_expire = (state_q == RUN) && wdt_tc && !bus.wdt_kick;
`else
   logic wdt_unused;
   assign wdt_unused = bus.wdt_kick ^ (WDT_CYCLES > 0);
   assign wdt_expire = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset_in) begin
         state_q  <= HOLD;
         cause_q  <= CAUSE_POR;
         periph_q <= 1'b0;
         run_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cause_q  <= cause_d;
         periph_q <= periph_d;
         run_q    <= run_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      case (state_q)
         HOLD: state_d = WAIT_LOCK;
         WAIT_LOCK: begin
            if (bus.pll_locked && seq_tc) state_d = PERIPH_WAIT;
         end
         PERIPH_WAIT: begin
            if (!bus.pll_locked) state_d = WAIT_LOCK;
            else if (seq_tc)     state_d = CPU_WAIT;
         end
         CPU_WAIT: begin
            if (!bus.pll_locked) state_d = WAIT_LOCK;
            else if (seq_tc)     state_d = RUN;
         end
         RUN: begin
            if (!bus.pll_locked) begin
               state_d = WAIT_LOCK;
               cause_d = CAUSE_LOCK;
            end else if (wdt_expire) begin
               state_d = SW_PULSE;
               cause_d = CAUSE_WDT;
            end else if (bus.sw_reset_req) begin
               state_d = SW_PULSE;
               cause_d = CAUSE_SW;
            end
         end
         SW_PULSE: begin
            if (!bus.pll_locked) state_d = WAIT_LOCK;
            else if (seq_tc)     state_d = PERIPH_WAIT;
         end
         default: state_d = HOLD;
      endcase
   end

   always_comb begin
      periph_d = (state_d == CPU_WAIT) || (state_d == RUN);
      run_d    = (state_d == RUN);
   end

   assign bus.periph_resetn = periph_q;
   assign bus.cpu_resetn    = run_q;
   assign bus.seq_done      = run_q;
   assign bus.rst_cause     = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed timing scenarios plus randomized traffic against a phase/duration model.
// Build with RESET_SEQ_WATCHDOG_EN defined to cover the watchdog path as well.
module tb_reset_sequencer;

   localparam int LF  = 4;
   localparam int PD  = 8;
   localparam int CD  = 16;
   localparam int SP  = 4;
   localparam int WDT = 16;

   localparam int P_HOLD = 0, P_LOCK = 1, P_PERIPH = 2, P_CPU = 3, P_RUN = 4, P_PULSE = 5;

   logic clk = 1'b0;
   logic reset_in;

   always #5 clk = ~clk;

   reset_sequencer_if bus();

   reset_sequencer #(
      .LOCK_FILTER  (LF),
      .PERIPH_DELAY (PD),
      .CPU_DELAY    (CD),
      .SW_PULSE_LEN (SP),
      .WDT_CYCLES   (WDT)
   ) dut (
      .clk      (clk),
      .reset_in (reset_in),
      .bus      (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Model: which phase we are in and how many edges have been spent there.
   int m_phase = P_HOLD;
   int m_spent = 0;
   int m_wdt   = 0;
   int m_cause = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_edge();
      bit wd_hit;
`ifdef RESET_SEQ_WATCHDOG_EN
      wd_hit = (m_wdt == WDT - 1) && !bus.wdt_kick;
`else
      wd_hit = 1'b0;
`endif
      if (reset_in) begin
         m_phase = P_HOLD; m_spent = 0; m_cause = 0;
      end else begin
         case (m_phase)
            P_HOLD: begin m_phase = P_LOCK; m_spent = 0; end
            P_LOCK: begin
               if (!bus.pll_locked) m_spent = 0;
               else if (m_spent + 1 == LF) begin m_phase = P_PERIPH; m_spent = 0; end
               else m_spent++;
            end
            P_PERIPH, P_CPU, P_PULSE: begin
               int need;
               need = (m_phase == P_PERIPH) ? PD : (m_phase == P_CPU) ? CD : SP;
               if (!bus.pll_locked) begin m_phase = P_LOCK; m_spent = 0; end
               else if (m_spent + 1 == need) begin
                  m_phase = (m_phase == P_PERIPH) ? P_CPU : (m_phase == P_CPU) ? P_RUN : P_PERIPH;
                  m_spent = 0;
                  m_wdt   = 0;
               end else m_spent++;
            end
            default: begin
               if (!bus.pll_locked) begin m_cause = 3; m_phase = P_LOCK; m_spent = 0; end
               else if (wd_hit)     begin m_cause = 2; m_phase = P_PULSE; m_spent = 0; end
               else if (bus.sw_reset_req) begin m_cause = 1; m_phase = P_PULSE; m_spent = 0; end
               else m_wdt = bus.wdt_kick ? 0 : m_wdt + 1;
            end
         endcase
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("periph_resetn", bus.periph_resetn, (m_phase == P_CPU || m_phase == P_RUN));
      check("cpu_resetn",    bus.cpu_resetn,    (m_phase == P_RUN));
      check("seq_done",      bus.seq_done,      (m_phase == P_RUN));
      check("rst_cause",     bus.rst_cause,     m_cause);
   endtask

   initial begin
      int kick_rate;
      reset_in         = 1'b1;
      bus.pll_locked   = 1'b1;
      bus.sw_reset_req = 1'b0;
      bus.wdt_kick     = 1'b1;

      // Power-on
      repeat (5) step();
      check("por_periph", bus.periph_resetn, 0);
      check("por_cpu",    bus.cpu_resetn,    0);
      check("por_done",   bus.seq_done,      0);
      check("por_cause",  bus.rst_cause,     0);
      reset_in = 1'b0;
      for (int e = 1; e <= 29; e++) begin
         step();
         if (e == 12) check("por_periph_e12", bus.periph_resetn, 0);
         if (e == 13) check("por_periph_e13", bus.periph_resetn, 1);
         if (e == 28) check("por_cpu_e28",    bus.cpu_resetn,    0);
         if (e == 29) begin
            check("por_cpu_e29",   bus.cpu_resetn, 1);
            check("por_done_e29",  bus.seq_done,   1);
            check("por_cause_e29", bus.rst_cause,  0);
         end
      end

      // Software reset from RUN
      bus.sw_reset_req = 1'b1;
      step();
      bus.sw_reset_req = 1'b0;
      check("sw_periph_low", bus.periph_resetn, 0);
      check("sw_cause",      bus.rst_cause,     1);
      for (int e = 1; e <= 28; e++) begin
         step();
         if (e == 11) check("sw_periph_e11", bus.periph_resetn, 0);
         if (e == 12) check("sw_periph_e12", bus.periph_resetn, 1);
         if (e == 27) check("sw_cpu_e27",    bus.cpu_resetn,    0);
         if (e == 28) check("sw_cpu_e28",    bus.cpu_resetn,    1);
      end

      // reset_in mid-RUN clears the recorded cause
      reset_in = 1'b1;
      step();
      check("mid_cause",  bus.rst_cause,     0);
      check("mid_periph", bus.periph_resetn, 0);
      check("mid_cpu",    bus.cpu_resetn,    0);
      check("mid_done",   bus.seq_done,      0);
      reset_in = 1'b0;

      // Lock glitch during the filter window delays release by four edges
      for (int e = 1; e <= 20; e++) begin
         bus.pll_locked = (e != 5);
         step();
         if (e == 16) check("glitch_periph_e16", bus.periph_resetn, 0);
         if (e == 17) check("glitch_periph_e17", bus.periph_resetn, 1);
      end

      // Lock loss in CPU_WAIT
      bus.pll_locked = 1'b0;
      step();
      check("ll_periph", bus.periph_resetn, 0);
      check("ll_cause",  bus.rst_cause,     0);
      bus.pll_locked = 1'b1;
      for (int e = 1; e <= 28; e++) begin
         step();
         if (e == 27) check("relock_cpu_e27", bus.cpu_resetn, 0);
         if (e == 28) check("relock_cpu_e28", bus.cpu_resetn, 1);
      end

`ifdef RESET_SEQ_WATCHDOG_EN
      bus.wdt_kick = 1'b0;
      for (int e = 1; e <= 16; e++) begin
         step();
         if (e == 15) check("wd_still_run", bus.seq_done,  1);
         if (e == 16) begin
            check("wd_cause", bus.rst_cause, 2);
            check("wd_done",  bus.seq_done,  0);
         end
      end
      for (int e = 1; e <= 128; e++) begin
         bus.wdt_kick = (e > 28) && (e % 10 == 0);
         step();
         if (e == 128) check("wd_kicked_alive", bus.seq_done, 1);
      end
`else
      bus.wdt_kick = 1'b0;
      for (int e = 1; e <= 2000; e++) begin
         step();
         if (e == 2000) check("nowd_alive", bus.seq_done, 1);
      end
`endif

      // Randomized traffic
      kick_rate = 4;
      for (int c = 0; c < 4000; c++) begin
         if (c % 500 == 0) kick_rate = $urandom_range(0, 24);
         reset_in         = ($urandom_range(0, 599) == 0);
         bus.pll_locked   = ($urandom_range(0, 79) != 0);
         bus.sw_reset_req = ($urandom_range(0, 49) == 0);
         bus.wdt_kick     = ($urandom_range(0, kick_rate) == 0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
